// File: rtl/imu_avg_pkg.sv
// Shared types and constants for the IMU boxcar frame averager.
package imu_avg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    EMIT = 2'd2
  } state_e;

  localparam int NUM_CH    = 6;
  localparam int CH_ACC_X  = 0;
  localparam int CH_ACC_Y  = 1;
  localparam int CH_ACC_Z  = 2;
  localparam int CH_GYRO_X = 3;
  localparam int CH_GYRO_Y = 4;
  localparam int CH_GYRO_Z = 5;

  // A sum of 2^log2_depth samples needs log2_depth extra bits to never overflow.
  function automatic int sum_width(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

endpackage

// File: rtl/imu_avg_frame_ram.sv
// Frame history store: DEPTH frames x 6 channels, combinational read, synchronous write.
module imu_avg_frame_ram
  import imu_avg_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [LOG2_DEPTH-1:0] wptr_i,
  input  logic [2:0]            wch_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [LOG2_DEPTH-1:0] rptr_i,
  input  logic [2:0]            rch_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem [2**LOG2_DEPTH][NUM_CH];

  // No reset: entries are only read once the window has been completely refilled.
  always_ff @(posedge clk) begin
    if (we_i) mem[wptr_i][wch_i] <= wdata_i;
  end

  assign rdata_o = mem[rptr_i][rch_i];

endmodule

// File: rtl/imu_frame_averager.sv
// Six-channel moving boxcar average over 2^LOG2_DEPTH frames, one shared adder walking the channels serially.
module imu_frame_averager
  import imu_avg_pkg::*;
#(
  parameter int LOG2_DEPTH = 3,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] acc_x,
  input  logic [DATA_W-1:0] acc_y,
  input  logic [DATA_W-1:0] acc_z,
  input  logic [DATA_W-1:0] gyro_x,
  input  logic [DATA_W-1:0] gyro_y,
  input  logic [DATA_W-1:0] gyro_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] avg_acc_x,
  output logic [DATA_W-1:0] avg_acc_y,
  output logic [DATA_W-1:0] avg_acc_z,
  output logic [DATA_W-1:0] avg_gyro_x,
  output logic [DATA_W-1:0] avg_gyro_y,
  output logic [DATA_W-1:0] avg_gyro_z,
  output logic              primed,
  output logic [15:0]       drop_count
);

  localparam int SUM_W = sum_width(DATA_W, LOG2_DEPTH);
  localparam logic [LOG2_DEPTH:0]   FILL_FULL = {1'b1, {LOG2_DEPTH{1'b0}}};
  localparam logic [LOG2_DEPTH:0]   FILL_ONE  = 1;
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE   = 1;
  localparam logic [2:0]            CH_LAST   = 3'(CH_GYRO_Z);

  state_e                               state_q, state_d;
  logic [2:0]                           ch_q, ch_d;
  logic [NUM_CH-1:0][DATA_W-1:0]        frame_q, frame_d, frame_in;
  logic [NUM_CH-1:0][SUM_W-1:0]         sum_q, sum_d;
  logic [NUM_CH-1:0][DATA_W-1:0]        avg_q, avg_d;
  logic [LOG2_DEPTH-1:0]                wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0]                  fill_q, fill_d;
  logic [15:0]                          drop_q, drop_d;

  logic              mem_we;
  logic [DATA_W-1:0] old_raw;
  logic [SUM_W-1:0]  new_ext, old_ext, sum_upd;

  imu_avg_frame_ram #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .wptr_i  (wr_ptr_q),
    .wch_i   (ch_q),
    .wdata_i (frame_q[ch_q]),
    .rptr_i  (wr_ptr_q),
    .rch_i   (ch_q),
    .rdata_o (old_raw)
  );

  always_comb begin
    frame_in            = '0;
    frame_in[CH_ACC_X]  = acc_x;
    frame_in[CH_ACC_Y]  = acc_y;
    frame_in[CH_ACC_Z]  = acc_z;
    frame_in[CH_GYRO_X] = gyro_x;
    frame_in[CH_GYRO_Y] = gyro_y;
    frame_in[CH_GYRO_Z] = gyro_z;
  end

  // Shared datapath: the sample leaving the window only counts once the window is full.
  assign new_ext = {{LOG2_DEPTH{frame_q[ch_q][DATA_W-1]}}, frame_q[ch_q]};
  assign old_ext = (fill_q == FILL_FULL) ? {{LOG2_DEPTH{old_raw[DATA_W-1]}}, old_raw} : '0;
  assign sum_upd = sum_q[ch_q] + new_ext - old_ext;

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    frame_d  = frame_q;
    sum_d    = sum_q;
    avg_d    = avg_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    drop_d   = drop_q;
    mem_we   = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      ch_d     = '0;
      sum_d    = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
      drop_d   = '0;
    end else begin
      if (in_valid && (state_q != IDLE) && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            frame_d = frame_in;
            ch_d    = '0;
            state_d = PROC;
          end
        end
        PROC: begin
          mem_we       = 1'b1;
          sum_d[ch_q]  = sum_upd;
          ch_d         = ch_q + 3'd1;
          if (ch_q == CH_LAST) begin
            ch_d     = '0;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (fill_q != FILL_FULL) fill_d = fill_q + FILL_ONE;
            if (fill_d == FILL_FULL) begin
              state_d = EMIT;
              // Arithmetic shift right by LOG2_DEPTH is just the top DATA_W bits of the sum.
              for (int c = 0; c < NUM_CH; c++) avg_d[c] = sum_d[c][SUM_W-1:LOG2_DEPTH];
            end else begin
              state_d = IDLE;
            end
          end
        end
        EMIT: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      frame_q  <= '0;
      sum_q    <= '0;
      avg_q    <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      frame_q  <= frame_d;
      sum_q    <= sum_d;
      avg_q    <= avg_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      drop_q   <= drop_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == EMIT);
  assign primed     = (fill_q == FILL_FULL);
  assign drop_count = drop_q;
  assign avg_acc_x  = avg_q[CH_ACC_X];
  assign avg_acc_y  = avg_q[CH_ACC_Y];
  assign avg_acc_z  = avg_q[CH_ACC_Z];
  assign avg_gyro_x = avg_q[CH_GYRO_X];
  assign avg_gyro_y = avg_q[CH_GYRO_Y];
  assign avg_gyro_z = avg_q[CH_GYRO_Z];

endmodule

// File: tb/tb_imu_frame_averager.sv
// Scoreboard bench for imu_frame_averager: a window model predicts each averaged frame.
module tb_imu_frame_averager;

  typedef logic [5:0][15:0] frame_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] acc_x = '0, acc_y = '0, acc_z = '0, gyro_x = '0, gyro_y = '0, gyro_z = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] avg_acc_x, avg_acc_y, avg_acc_z, avg_gyro_x, avg_gyro_y, avg_gyro_z;
  logic        primed;
  logic [15:0] drop_count;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     n_out    = 0;
  int     drop_exp = 0;
  frame_t win[$];
  frame_t exp_q[$];
  frame_t mon_e, mon_got, last_e;

  imu_frame_averager #(.LOG2_DEPTH(3), .DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .avg_acc_x(avg_acc_x), .avg_acc_y(avg_acc_y), .avg_acc_z(avg_acc_z),
    .avg_gyro_x(avg_gyro_x), .avg_gyro_y(avg_gyro_y), .avg_gyro_z(avg_gyro_z),
    .primed(primed), .drop_count(drop_count)
  );

  always #10 clk = ~clk;

  function automatic frame_t mk(input int a, input int b, input int c,
                                input int d, input int e, input int g);
    return {16'(g), 16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic frame_t got_frame();
    return {avg_gyro_z, avg_gyro_y, avg_gyro_x, avg_acc_z, avg_acc_y, avg_acc_x};
  endfunction

  // Reference window: keep the last 8 accepted frames, floor-average once full.
  task automatic model_push(input frame_t f);
    frame_t e;
    int     s;
    win.push_back(f);
    if (win.size() > 8) void'(win.pop_front());
    if (win.size() == 8) begin
      for (int c = 0; c < 6; c++) begin
        s = 0;
        for (int k = 0; k < 8; k++) s = s + int'($signed(win[k][c]));
        e[c] = 16'(s >>> 3);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic model_flush();
    win.delete();
    exp_q.delete();
    drop_exp = 0;
  endtask

  // Scoreboard: every completed output handshake pops one predicted frame.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      n_out++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output got=%h required=none", got_frame());
      end else begin
        mon_e   = exp_q.pop_front();
        mon_got = got_frame();
        last_e  = mon_e;
        if (mon_got !== mon_e) $display("FAIL avg_frame got=%h required=%h", mon_got, mon_e);
        else n_pass++;
        n_checks++;
        if (primed !== 1'b1) $display("FAIL primed_at_output got=%b required=1", primed);
        else n_pass++;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL idle_timeout got=in_ready=%b required=1", in_ready);
    end
  endtask

  task automatic send(input frame_t f);
    wait_idle();
    {gyro_z, gyro_y, gyro_x, acc_z, acc_y, acc_x} = f;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_push(f);
  endtask

  task automatic pulse_clear();
    wait_idle();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_flush();
  endtask

  task automatic test_reset();
    #5;
    n_checks++;
    if (out_valid !== 1'b0 || primed !== 1'b0 || drop_count !== 16'd0 || got_frame() !== '0)
      $display("FAIL reset_state got=ov%b pr%b dc%0d avg=%h required=all zero",
               out_valid, primed, drop_count, got_frame());
    else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b required=1", in_ready);
    else n_pass++;
  endtask

  task automatic test_fill();
    int n0, lat;
    out_ready = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 7; i++) send(mk(100, 100, 100, 100, 100, 100));
    wait_idle();
    n_checks++;
    if (n_out !== n0 || primed !== 1'b0)
      $display("FAIL fill_no_output got=outs%0d primed%b required=outs%0d primed0", n_out, primed, n0);
    else n_pass++;
    send(mk(100, 100, 100, 100, 100, 100));
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
    n_checks++;
    if (lat !== 7) $display("FAIL latency got=%0d required=7", lat);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_step();
    send(mk(1000, 100, 100, 100, 100, 100));
    wait_idle();
    n_checks++;
    if (avg_acc_x !== 16'd212 || avg_gyro_z !== 16'd100)
      $display("FAIL step_avg got=ax%0d gz%0d required=ax212 gz100", avg_acc_x, avg_gyro_z);
    else n_pass++;
  endtask

  task automatic test_sign();
    pulse_clear();
    for (int i = 0; i < 8; i++) send(mk(0, 0, 0, 0, 0, -3));
    wait_idle();
    n_checks++;
    if (avg_gyro_z !== 16'hFFFD) $display("FAIL sign_neg3 got=%h required=fffd", avg_gyro_z);
    else n_pass++;
    pulse_clear();
    for (int i = 0; i < 7; i++) send(mk(0, 0, 0, 0, 0, 0));
    send(mk(0, -1, 0, 0, 0, 0));
    wait_idle();
    n_checks++;
    if (avg_acc_y !== 16'hFFFF) $display("FAIL floor_neg1 got=%h required=ffff", avg_acc_y);
    else n_pass++;
    pulse_clear();
    for (int i = 0; i < 8; i++) send(mk(-32768, -32768, -32768, -32768, -32768, -32768));
    wait_idle();
    n_checks++;
    if (avg_acc_z !== 16'h8000) $display("FAIL min_value got=%h required=8000", avg_acc_z);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int n = 0;
    out_ready = 1'b0;
    send(mk(8, 16, -24, 40, 0, 7));
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b required=1", out_valid);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      drop_exp++;
    end
    n_checks++;
    if (drop_count !== 16'(drop_exp) || out_valid !== 1'b1)
      $display("FAIL bp_drops got=%0d ov%b required=%0d ov1", drop_count, out_valid, drop_exp);
    else n_pass++;
    n_checks++;
    if (exp_q.size() == 0 || got_frame() !== exp_q[0])
      $display("FAIL bp_hold got=%h required=predicted frame", got_frame());
    else n_pass++;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drop_exp++;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || drop_count !== 16'(drop_exp))
      $display("FAIL bp_release got=ov%b ir%b dc%0d required=ov0 ir1 dc%0d",
               out_valid, in_ready, drop_count, drop_exp);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n0;
    send(mk(11, 22, 33, 44, 55, 66));
    @(posedge clk); @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    model_flush();
    n_checks++;
    if (out_valid !== 1'b0 || primed !== 1'b0 || drop_count !== 16'd0 || got_frame() !== '0)
      $display("FAIL mid_reset got=ov%b pr%b dc%0d avg=%h required=all zero",
               out_valid, primed, drop_count, got_frame());
    else n_pass++;
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    n0 = n_out;
    for (int i = 0; i < 7; i++) send(mk(i * 10 - 30, -i, i * 7, 5, -1000 + i, 300 - i * 3));
    wait_idle();
    n_checks++;
    if (n_out !== n0) $display("FAIL mid_reset_early got=outs%0d required=%0d", n_out, n0);
    else n_pass++;
    send(mk(70, 9, -2, 5, 123, -77));
    wait_idle();
    n_checks++;
    if (n_out !== n0 + 1) $display("FAIL mid_reset_8th got=outs%0d required=%0d", n_out, n0 + 1);
    else n_pass++;
  endtask

  task automatic test_clear();
    int     n0;
    frame_t hold;
    send(mk(1, 2, 3, 4, 5, 6));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drop_exp++;
    wait_idle();
    n_checks++;
    if (drop_count !== 16'(drop_exp)) $display("FAIL proc_drop got=%0d required=%0d", drop_count, drop_exp);
    else n_pass++;
    hold = last_e;
    clear    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    model_flush();
    n_checks++;
    if (primed !== 1'b0 || drop_count !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL clear_state got=pr%b dc%0d ov%b ir%b required=pr0 dc0 ov0 ir1",
               primed, drop_count, out_valid, in_ready);
    else n_pass++;
    n_checks++;
    if (got_frame() !== hold) $display("FAIL clear_avg_hold got=%h required=%h", got_frame(), hold);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL clear_frame_ignored got=ir%b required=1", in_ready);
    else n_pass++;
    n0 = n_out;
    for (int i = 0; i < 7; i++) send(mk(-i, i, 2 * i, -2 * i, 500, -500));
    wait_idle();
    n_checks++;
    if (n_out !== n0) $display("FAIL clear_early got=outs%0d required=%0d", n_out, n0);
    else n_pass++;
    send(mk(40, -40, 8, 8, 508, -492));
    wait_idle();
    n_checks++;
    if (n_out !== n0 + 1) $display("FAIL clear_8th got=outs%0d required=%0d", n_out, n0 + 1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_step();
    test_sign();
    test_backpressure();
    test_reset_mid();
    test_clear();
    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL pending_outputs got=%0d required=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
